// File: rtl/mem_access.sv
// Memory-access pipeline stage: formats loads/stores onto a single-cycle-ack bus and stalls the pipe until done.
// Optional MEM_TIMEOUT_EN builds an 8-bit bus timeout that forces DONE and pulses bus_err_o.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic        ld_src_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_mem,
    output logic        addr_err_o,
    output logic        bus_err_o
);
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, bwdata_q, bwdata_d, rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;

    logic        is_mem, is_store, sign_ext, misalign;
    logic [1:0]  size;
    logic [3:0]  fmt_be;
    logic [31:0] st_wdata, ld_data, lane_b, lane_h;

`ifdef MEM_TIMEOUT_EN
    logic [7:0]  tmo_q, tmo_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        is_mem   = 1'b0;
        is_store = 1'b0;
        sign_ext = 1'b0;
        size     = SZ_WORD;
        if (ld_src_i) begin
            case (aluop_i)
                OP_LB:  begin is_mem = 1'b1; sign_ext = 1'b1; size = SZ_BYTE; end
                OP_LBU: begin is_mem = 1'b1; size = SZ_BYTE; end
                OP_LH:  begin is_mem = 1'b1; sign_ext = 1'b1; size = SZ_HALF; end
                OP_LHU: begin is_mem = 1'b1; size = SZ_HALF; end
                OP_LW:  begin is_mem = 1'b1; end
                OP_SB:  begin is_mem = 1'b1; is_store = 1'b1; size = SZ_BYTE; end
                OP_SH:  begin is_mem = 1'b1; is_store = 1'b1; size = SZ_HALF; end
                OP_SW:  begin is_mem = 1'b1; is_store = 1'b1; end
                default: ;
            endcase
        end
        misalign = ((size == SZ_HALF) && mem_addr_i[0]) ||
                   ((size == SZ_WORD) && (mem_addr_i[1:0] != 2'b00));
    end

    // Same byte-enable pattern serves loads and stores of a given size.
    always_comb begin
        lane_b = bus_rdata_i >> {mem_addr_i[1:0], 3'b000};
        lane_h = bus_rdata_i >> {mem_addr_i[1], 4'b0000};
        case (size)
            SZ_BYTE: begin
                fmt_be   = 4'b0001 << mem_addr_i[1:0];
                st_wdata = {4{reg2_i[7:0]}};
                ld_data  = sign_ext ? {{24{lane_b[7]}}, lane_b[7:0]} : {24'd0, lane_b[7:0]};
            end
            SZ_HALF: begin
                fmt_be   = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{reg2_i[15:0]}};
                ld_data  = sign_ext ? {{16{lane_h[15]}}, lane_h[15:0]} : {16'd0, lane_h[15:0]};
            end
            default: begin
                fmt_be   = 4'b1111;
                st_wdata = reg2_i;
                ld_data  = bus_rdata_i;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        be_d         = be_q;
        bwdata_d     = bwdata_q;
        rdata_d      = rdata_q;
        stallreq_mem = 1'b0;
        addr_err_o   = 1'b0;
        wd_o         = wd_i;
        wreg_o       = wreg_i;
        wdata_o      = wdata_i;
`ifdef MEM_TIMEOUT_EN
        tmo_d        = tmo_q;
        err_d        = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (is_mem) begin
                    wreg_o = 1'b0;
                    if (misalign) begin
                        addr_err_o = 1'b1;
                    end else begin
                        stallreq_mem = 1'b1;
                        state_d      = S_BUSY;
                        req_d        = 1'b1;
                        we_d         = is_store;
                        addr_d       = {mem_addr_i[31:2], 2'b00};
                        be_d         = fmt_be;
                        bwdata_d     = st_wdata;
`ifdef MEM_TIMEOUT_EN
                        tmo_d        = 8'd0;
`endif
                    end
                end
            end
            S_BUSY: begin
                stallreq_mem = 1'b1;
                wreg_o       = 1'b0;
                if (bus_ack_i) begin
                    req_d   = 1'b0;
                    rdata_d = ld_data;
                    state_d = S_DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (tmo_q == 8'd254) begin
                    // this cycle brings the count to 255: give up on the bus
                    tmo_d   = 8'd255;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
                wdata_o = we_q ? wdata_i : rdata_q;
`ifdef MEM_TIMEOUT_EN
                if (err_q) wreg_o = 1'b0;
`endif
            end
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            stallreq_mem = 1'b0;
            addr_err_o   = 1'b0;
            wreg_o       = 1'b0;
            wd_o         = 5'd0;
            wdata_o      = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            be_q     <= 4'd0;
            bwdata_q <= 32'd0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            bwdata_q <= bwdata_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign bus_err_o = err_q;
`else
    assign bus_err_o = 1'b0;
`endif

    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_be_o    = be_q;
    assign bus_wdata_o = bwdata_q;
endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access against a transaction-level model of the memory stage.
module tb_mem_access;
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic        ld_src_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] reg2_i;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_mem, addr_err_o, bus_err_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst(rst),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .ld_src_i(ld_src_i),
        .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .stallreq_mem(stallreq_mem), .addr_err_o(addr_err_o), .bus_err_o(bus_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // size in bytes, 0 when the op is not a memory op
    function automatic int op_bytes(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit op_store(input logic [7:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [3:0] exp_be(input int nb, input logic [31:0] a);
        int base;
        logic [3:0] m;
        base = int'(a[1:0]);
        m = 4'd0;
        for (int k = 0; k < nb; k++) m[base + k] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] exp_store_data(input int nb, input logic [31:0] r);
        logic [31:0] v;
        v = r;
        if (nb == 1) v = r[7:0] * 32'h0101_0101;
        if (nb == 2) v = r[15:0] * 32'h0001_0001;
        return v;
    endfunction

    function automatic logic [31:0] exp_load(input logic [7:0] op, input logic [31:0] a, input logic [31:0] rd);
        int     val;
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[8*int'(a[1:0]) +: 8];
        h = rd[16*int'(a[1]) +: 16];
        case (op)
            OP_LB:   val = int'(b) - ((b >= 8'd128) ? 256 : 0);
            OP_LBU:  val = int'(b);
            OP_LH:   val = int'(h) - ((h >= 16'h8000) ? 65536 : 0);
            OP_LHU:  val = int'(h);
            default: val = int'(rd);
        endcase
        return 32'(val);
    endfunction

    // Called just after a rising edge with the DUT idle; returns in the same phase.
    task automatic run_op(input logic [7:0] op, input logic lsrc, input logic [31:0] a,
                          input logic [31:0] r2, input logic [4:0] wd, input logic wr,
                          input logic [31:0] wdat, input int delay, input logic [31:0] rd);
        int nb;
        bit st;
        nb = lsrc ? op_bytes(op) : 0;
        st = op_store(op);
        aluop_i = op; ld_src_i = lsrc; mem_addr_i = a; reg2_i = r2;
        wd_i = wd; wreg_i = wr; wdata_i = wdat; bus_ack_i = 1'b0; bus_rdata_i = $urandom;
        @(negedge clk);
        if (nb == 0) begin
            chk("pass_stall", 32'(stallreq_mem), 32'd0);
            chk("pass_wreg", 32'(wreg_o), 32'(wr));
            chk("pass_wd", 32'(wd_o), 32'(wd));
            chk("pass_wdata", wdata_o, wdat);
            chk("pass_req", 32'(bus_req_o), 32'd0);
            chk("pass_aerr", 32'(addr_err_o), 32'd0);
            @(posedge clk); #1;
            return;
        end
        if ((int'(a[1:0]) % nb) != 0) begin
            chk("mis_aerr", 32'(addr_err_o), 32'd1);
            chk("mis_stall", 32'(stallreq_mem), 32'd0);
            chk("mis_wreg", 32'(wreg_o), 32'd0);
            chk("mis_req", 32'(bus_req_o), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("mis_req_next", 32'(bus_req_o), 32'd0);
            @(posedge clk); #1;
            return;
        end
        chk("idle_stall", 32'(stallreq_mem), 32'd1);
        chk("idle_wreg", 32'(wreg_o), 32'd0);
        chk("idle_req", 32'(bus_req_o), 32'd0);
        chk("idle_aerr", 32'(addr_err_o), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i <= delay; i++) begin
            if (i == delay) begin
                bus_ack_i = 1'b1;
                bus_rdata_i = rd;
            end
            @(negedge clk);
            chk("busy_stall", 32'(stallreq_mem), 32'd1);
            chk("busy_wreg", 32'(wreg_o), 32'd0);
            chk("busy_req", 32'(bus_req_o), 32'd1);
            chk("busy_we", 32'(bus_we_o), 32'(st));
            chk("busy_addr", bus_addr_o, a & 32'hFFFF_FFFC);
            chk("busy_be", 32'(bus_be_o), 32'(exp_be(nb, a)));
            if (st) chk("busy_wdata", bus_wdata_o, exp_store_data(nb, r2));
            @(posedge clk); #1;
            bus_ack_i = 1'b0;
            bus_rdata_i = $urandom;
        end
        @(negedge clk);
        chk("done_stall", 32'(stallreq_mem), 32'd0);
        chk("done_req", 32'(bus_req_o), 32'd0);
        chk("done_wreg", 32'(wreg_o), 32'(wr));
        chk("done_wd", 32'(wd_o), 32'(wd));
        chk("done_wdata", wdata_o, st ? wdat : exp_load(op, a, rd));
        chk("done_berr", 32'(bus_err_o), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] ops [10];
        logic [7:0] op;
        logic [31:0] a;
        ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, 8'h21, 8'h00};

        rst = 1'b1; wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'hCAFE_0001; ld_src_i = 1'b0;
        aluop_i = 8'd0; mem_addr_i = 32'd0; reg2_i = 32'd0; bus_ack_i = 1'b0; bus_rdata_i = 32'd0;
        #12;
        chk("rst_stall", 32'(stallreq_mem), 32'd0);
        chk("rst_wreg", 32'(wreg_o), 32'd0);
        chk("rst_wd", 32'(wd_o), 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_req", 32'(bus_req_o), 32'd0);
        chk("rst_be", 32'(bus_be_o), 32'd0);
        chk("rst_berr", 32'(bus_err_o), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        run_op(OP_LW,  1'b1, 32'h0000_1004, 32'd0, 5'd3, 1'b1, 32'h1111_1111, 0, 32'hDEAD_BEEF);
        run_op(OP_LB,  1'b1, 32'h0000_2003, 32'd0, 5'd4, 1'b1, 32'h0, 0, 32'h80FF_FFFF);
        run_op(OP_LBU, 1'b1, 32'h0000_2003, 32'd0, 5'd4, 1'b1, 32'h0, 1, 32'h80FF_FFFF);
        run_op(OP_LHU, 1'b1, 32'h0000_2002, 32'd0, 5'd4, 1'b1, 32'h0, 2, 32'h80FF_FFFF);
        run_op(OP_SH,  1'b1, 32'h0000_3002, 32'h1234_5678, 5'd0, 1'b0, 32'h0000_3002, 0, 32'h0);
        run_op(OP_SB,  1'b1, 32'h0000_3001, 32'h1234_5678, 5'd0, 1'b0, 32'h0000_3001, 1, 32'h0);
        run_op(OP_LW,  1'b1, 32'h0000_0006, 32'd0, 5'd5, 1'b1, 32'h0, 0, 32'h0);
        run_op(OP_LW,  1'b0, 32'h0000_0006, 32'd0, 5'd6, 1'b1, 32'h7777_0000, 0, 32'h0);

        for (int n = 0; n < 200; n++) begin
            op = ops[$urandom_range(0, 9)];
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            run_op(op, ($urandom_range(0, 7) != 0), a, $urandom, 5'($urandom), 1'($urandom),
                   $urandom, $urandom_range(0, 4), $urandom);
        end

        // reset in the middle of a bus access, with a coincident ack on the next edge
        aluop_i = OP_LW; ld_src_i = 1'b1; mem_addr_i = 32'h0000_4000; wreg_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_req_before", 32'(bus_req_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_req_rst", 32'(bus_req_o), 32'd0);
        chk("mid_stall_rst", 32'(stallreq_mem), 32'd0);
        chk("mid_wreg_rst", 32'(wreg_o), 32'd0);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h5555_AAAA;
        @(posedge clk); #1;
        chk("mid_req_ack", 32'(bus_req_o), 32'd0);
        bus_ack_i = 1'b0; ld_src_i = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        run_op(OP_LH, 1'b1, 32'h0000_5002, 32'd0, 5'd7, 1'b1, 32'h0, 1, 32'h8001_0000);

        // bus that never acknowledges
        aluop_i = OP_LW; ld_src_i = 1'b1; mem_addr_i = 32'h0000_6000; wreg_i = 1'b1;
        wd_i = 5'd8; bus_ack_i = 1'b0;
        @(posedge clk); #1;
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            chk("tmo_busy_req", 32'(bus_req_o), 32'd1);
            chk("tmo_busy_err", 32'(bus_err_o), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("tmo_err", 32'(bus_err_o), 32'd1);
        chk("tmo_req", 32'(bus_req_o), 32'd0);
        chk("tmo_wreg", 32'(wreg_o), 32'd0);
        chk("tmo_stall", 32'(stallreq_mem), 32'd0);
        ld_src_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("tmo_err_pulse", 32'(bus_err_o), 32'd0);
`else
        repeat (300) @(posedge clk);
        @(negedge clk);
        chk("hang_req", 32'(bus_req_o), 32'd1);
        chk("hang_stall", 32'(stallreq_mem), 32'd1);
        chk("hang_berr", 32'(bus_err_o), 32'd0);
        rst = 1'b1; ld_src_i = 1'b0;
        #1;
        chk("hang_req_rst", 32'(bus_req_o), 32'd0);
        @(negedge clk); rst = 1'b0;
`endif
        @(posedge clk); #1;
        run_op(OP_SW, 1'b1, 32'h0000_7008, 32'hA5A5_5A5A, 5'd1, 1'b0, 32'h0000_7008, 0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
